// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I core constants and the fetch-valid FSM encoding.
package riscv_pkg;
  localparam int W_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef enum logic {RESET_BUBBLE, RUN} fetch_state_t;
endpackage

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: PCF register with next-PC mux (redirect > stall > PC+4); ports: clk, rst_n, stallF, pcsrcE, pctargetE in; pcF, pcplus4F out.
module pc_reg #(
  parameter int W = 32,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stallF,
  input  logic         pcsrcE,
  input  logic [W-1:0] pctargetE,
  output logic [W-1:0] pcF,
  output logic [W-1:0] pcplus4F
);
  logic [W-1:0] pc_q, pc_d;
  logic en;
  assign pcplus4F = pc_q + W'(4);
  assign pcF = pc_q;
  always_comb begin
    en = pcsrcE | ~stallF;
    pc_d = pcsrcE ? pctargetE : pcplus4F;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else if (en) pc_q <= pc_d;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage + IF/ID register; in: clk, rst_n, stallF, stallD, flushD, pcsrcE, pctargetE, instrF; out: pcF, instrD, pcD, pcplus4D, validD, misalignD.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEFAULT)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stallF,
  input  logic         stallD,
  input  logic         flushD,
  input  logic         pcsrcE,
  input  logic [W-1:0] pctargetE,
  input  logic [W-1:0] instrF,
  output logic [W-1:0] pcF,
  output logic [W-1:0] instrD,
  output logic [W-1:0] pcD,
  output logic [W-1:0] pcplus4D,
  output logic         validD,
  output logic         misalignD
);
  localparam logic [W-1:0] NOP = W'(NOP_INSTR);
  logic [W-1:0] pcplus4F;
  logic [W-1:0] instr_q, instr_d, pc_q, pc_d, p4_q, p4_d;
  logic valid_q, valid_d, mis_q, mis_d, misf_q, misf_d, cap_valid;
  fetch_state_t fv_q, fv_d;
  pc_reg #(.W(W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .pcsrcE(pcsrcE),
    .pctargetE(pctargetE), .pcF(pcF), .pcplus4F(pcplus4F)
  );
  // A capture is a real instruction once the PC has advanced past reset
  // (or is advancing on this very edge).
  always_comb begin
    fv_d = (fv_q == RESET_BUBBLE && !stallF) ? RUN : fv_q;
    cap_valid = (fv_q == RUN) || !stallF;
    misf_d = pcsrcE ? |pctargetE[1:0] : (stallF ? misf_q : 1'b0);
    instr_d = flushD ? NOP : (stallD ? instr_q : instrF);
    pc_d = flushD ? '0 : (stallD ? pc_q : pcF);
    p4_d = flushD ? '0 : (stallD ? p4_q : pcplus4F);
    valid_d = flushD ? 1'b0 : (stallD ? valid_q : cap_valid);
    mis_d = flushD ? 1'b0 : (stallD ? mis_q : misf_q);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fv_q <= RESET_BUBBLE;
      misf_q <= 1'b0;
      instr_q <= NOP;
      pc_q <= '0;
      p4_q <= '0;
      valid_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      fv_q <= fv_d;
      misf_q <= misf_d;
      instr_q <= instr_d;
      pc_q <= pc_d;
      p4_q <= p4_d;
      valid_q <= valid_d;
      mis_q <= mis_d;
    end
  end
  assign instrD = instr_q;
  assign pcD = pc_q;
  assign pcplus4D = p4_q;
  assign validD = valid_q;
  assign misalignD = mis_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized run against a behavioural fetch/IF-ID model.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst_n, stallF, stallD, flushD, pcsrcE;
  logic [31:0] pctargetE, instrF, pcF, instrD, pcD, pcplus4D;
  logic validD, misalignD;
  int n_checks = 0, n_fail = 0;
  bit const_mem = 1'b1;
  logic [31:0] m_pc, m_instr, m_pcd, m_p4;
  logic m_valid, m_misd, m_misf, m_started;
  always #5 clk = ~clk;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return const_mem ? 32'h00A00093 : ({a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h0000_0013);
  endfunction
  assign instrF = mem(pcF);
  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .pcsrcE(pcsrcE), .pctargetE(pctargetE), .instrF(instrF), .pcF(pcF),
    .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD), .misalignD(misalignD)
  );
  task automatic step(input logic r, sf, sd, fd, ps, input logic [31:0] t);
    rst_n = r; stallF = sf; stallD = sd; flushD = fd; pcsrcE = ps; pctargetE = t;
    @(posedge clk);
    if (!r) begin
      m_pc = 32'h0; m_misf = 0; m_started = 0;
      m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_valid = 0; m_misd = 0;
    end else begin
      if (fd) begin
        m_instr = 32'h13; m_pcd = 0; m_p4 = 0; m_valid = 0; m_misd = 0;
      end else if (!sd) begin
        m_instr = mem(m_pc); m_pcd = m_pc; m_p4 = m_pc + 4; m_valid = m_started || !sf; m_misd = m_misf;
      end
      m_started = m_started || !sf;
      if (ps) begin m_pc = t; m_misf = (t[1:0] != 2'b00); end
      else if (!sf) begin m_pc = m_pc + 4; m_misf = 0; end
    end
    #1;
  endtask
  task automatic test_reset;
    step(0, 1, 1, 0, 1, 32'h44);
    if (pcF !== 32'h0) begin n_fail++; $display("FAIL reset_pcF got=%h exp=%h", pcF, 32'h0); end n_checks++;
    if (instrD !== 32'h13) begin n_fail++; $display("FAIL reset_instrD got=%h exp=%h", instrD, 32'h13); end n_checks++;
    if (pcD !== 32'h0) begin n_fail++; $display("FAIL reset_pcD got=%h exp=0", pcD); end n_checks++;
    if (pcplus4D !== 32'h0) begin n_fail++; $display("FAIL reset_pcplus4D got=%h exp=0", pcplus4D); end n_checks++;
    if (validD !== 1'b0) begin n_fail++; $display("FAIL reset_validD got=%b exp=0", validD); end n_checks++;
    if (misalignD !== 1'b0) begin n_fail++; $display("FAIL reset_misalignD got=%b exp=0", misalignD); end n_checks++;
  endtask
  task automatic test_sequential;
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 0, 0);
      if (pcF !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pcF got=%h exp=%h", pcF, 32'(4 * i)); end n_checks++;
      if (pcD !== 32'(4 * i - 4)) begin n_fail++; $display("FAIL seq_pcD got=%h exp=%h", pcD, 32'(4 * i - 4)); end n_checks++;
      if (pcplus4D !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pcplus4D got=%h exp=%h", pcplus4D, 32'(4 * i)); end n_checks++;
      if (validD !== 1'b1) begin n_fail++; $display("FAIL seq_validD got=%b exp=1", validD); end n_checks++;
      if (instrD !== 32'h00A00093) begin n_fail++; $display("FAIL seq_instrD got=%h exp=00a00093", instrD); end n_checks++;
    end
  endtask
  task automatic test_stall;
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 1, 0, 0, 0);
      if (pcF !== 32'h8) begin n_fail++; $display("FAIL stall_pcF got=%h exp=8", pcF); end n_checks++;
      if (pcD !== 32'h4) begin n_fail++; $display("FAIL stall_pcD got=%h exp=4", pcD); end n_checks++;
      if (validD !== 1'b1) begin n_fail++; $display("FAIL stall_validD got=%b exp=1", validD); end n_checks++;
      if (instrD !== 32'h00A00093) begin n_fail++; $display("FAIL stall_instrD got=%h exp=00a00093", instrD); end n_checks++;
    end
    step(1, 0, 0, 0, 0, 0);
    if (pcF !== 32'hC) begin n_fail++; $display("FAIL stall_resume_pcF got=%h exp=c", pcF); end n_checks++;
    if (pcD !== 32'h8) begin n_fail++; $display("FAIL stall_resume_pcD got=%h exp=8", pcD); end n_checks++;
  endtask
  task automatic test_redirect_flush;
    const_mem = 1'b0;
    step(1, 0, 0, 1, 1, 32'h100);
    if (pcF !== 32'h100) begin n_fail++; $display("FAIL redir_pcF got=%h exp=100", pcF); end n_checks++;
    if (instrD !== 32'h13) begin n_fail++; $display("FAIL redir_instrD got=%h exp=13", instrD); end n_checks++;
    if (validD !== 1'b0) begin n_fail++; $display("FAIL redir_validD got=%b exp=0", validD); end n_checks++;
    step(1, 0, 0, 0, 0, 0);
    if (pcD !== 32'h100) begin n_fail++; $display("FAIL redir_next_pcD got=%h exp=100", pcD); end n_checks++;
    if (instrD !== mem(32'h100)) begin n_fail++; $display("FAIL redir_next_instrD got=%h exp=%h", instrD, mem(32'h100)); end n_checks++;
    if (validD !== 1'b1) begin n_fail++; $display("FAIL redir_next_validD got=%b exp=1", validD); end n_checks++;
  endtask
  task automatic test_flush_stall;
    step(1, 0, 1, 1, 0, 0);
    if (instrD !== 32'h13) begin n_fail++; $display("FAIL flushstall_instrD got=%h exp=13", instrD); end n_checks++;
    if (validD !== 1'b0) begin n_fail++; $display("FAIL flushstall_validD got=%b exp=0", validD); end n_checks++;
  endtask
  task automatic test_misalign;
    step(1, 0, 0, 0, 1, 32'h102);
    if (pcF !== 32'h102) begin n_fail++; $display("FAIL mis_pcF got=%h exp=102", pcF); end n_checks++;
    step(1, 0, 0, 0, 0, 0);
    if (pcD !== 32'h102 || misalignD !== 1'b1) begin n_fail++; $display("FAIL mis_set pcD=%h misalignD=%b exp pcD=102 misalignD=1", pcD, misalignD); end n_checks++;
    step(1, 0, 0, 0, 0, 0);
    if (pcD !== 32'h106 || misalignD !== 1'b0) begin n_fail++; $display("FAIL mis_clear pcD=%h misalignD=%b exp pcD=106 misalignD=0", pcD, misalignD); end n_checks++;
  endtask
  task automatic test_reset_midstream;
    step(1, 0, 0, 0, 1, 32'h40);
    step(0, 0, 0, 0, 1, 32'h200);
    if (pcF !== 32'h0) begin n_fail++; $display("FAIL midrst_pcF got=%h exp=0", pcF); end n_checks++;
    if (instrD !== 32'h13 || pcD !== 0 || pcplus4D !== 0 || validD !== 0 || misalignD !== 0) begin
      n_fail++; $display("FAIL midrst_D instrD=%h pcD=%h pcplus4D=%h validD=%b misalignD=%b exp reset values", instrD, pcD, pcplus4D, validD, misalignD);
    end n_checks++;
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 0, 0);
    if (pcF !== 32'h0) begin n_fail++; $display("FAIL wrap_pcF got=%h exp=0", pcF); end n_checks++;
    if (pcplus4D !== 32'h0 || pcD !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_D pcD=%h pcplus4D=%h exp fffffffc/0", pcD, pcplus4D); end n_checks++;
  endtask
  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), $urandom);
      if (pcF !== m_pc) begin n_fail++; $display("FAIL rnd_pcF got=%h exp=%h", pcF, m_pc); end n_checks++;
      if (instrD !== m_instr) begin n_fail++; $display("FAIL rnd_instrD got=%h exp=%h", instrD, m_instr); end n_checks++;
      if (pcD !== m_pcd) begin n_fail++; $display("FAIL rnd_pcD got=%h exp=%h", pcD, m_pcd); end n_checks++;
      if (pcplus4D !== m_p4) begin n_fail++; $display("FAIL rnd_pcplus4D got=%h exp=%h", pcplus4D, m_p4); end n_checks++;
      if (validD !== m_valid) begin n_fail++; $display("FAIL rnd_validD got=%b exp=%b", validD, m_valid); end n_checks++;
      if (misalignD !== m_misd) begin n_fail++; $display("FAIL rnd_misalignD got=%b exp=%b", misalignD, m_misd); end n_checks++;
    end
  endtask
  initial begin
    test_reset;
    test_sequential;
    test_stall;
    test_redirect_flush;
    test_flush_stall;
    test_misalign;
    test_reset_midstream;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
